// File: rtl/netlist_stim_capture_pkg.sv
// Shared types and constants for the netlist stimulus/capture harness:
// FSM state encoding, the Galois polynomial and the fallback seed.
package netlist_stim_capture_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One right-shift Galois step with an extra data bit folded into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input logic din);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000) ^ {15'b0, din};
    endfunction

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    function automatic logic [15:0] safe_seed(input logic [15:0] seed);
        safe_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/nlsc_lfsr16.sv
// 16-bit Galois shift register with enable, synchronous load and a data-in bit.
// Used both as the stimulus LFSR (din tied 0) and as the response MISR.
module nlsc_lfsr16
    import netlist_stim_capture_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        din_i,
    output logic [15:0] val_o
);

    logic [15:0] val_q;
    logic [15:0] val_d;

    // Next state: a reload wins over a shift step.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (en_i) begin
            val_d = lfsr_next(val_q, din_i);
        end else begin
            val_d = val_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            val_q <= RESET_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/netlist_stim_capture.sv
// Stimulus/response harness around a combinational cone: LFSR vectors in, MISR
// signature and ones count out. Optional pause input under NETLIST_STIM_CAPTURE_PAUSE_EN.
module netlist_stim_capture
    import netlist_stim_capture_pkg::*;
#(
    parameter int          IN_W       = 13,
    parameter int          NUM_VEC    = 256,
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         CW         = $clog2(NUM_VEC + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
    input  logic            pause,
`endif
    input  logic            start,
    output logic [IN_W-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic [15:0]     sig,
    output logic [CW-1:0]   ones_cnt,
    output logic [CW-1:0]   vec_cnt
);

    localparam logic [15:0] SEED_EFF    = safe_seed(SEED);
    localparam int          SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CW-1:0] VEC_LAST    = CW'(NUM_VEC - 1);

    state_e        state_q;
    logic [SW-1:0] settle_cnt_q;
    logic [CW-1:0] ones_q;
    logic [CW-1:0] vec_q;
    logic          busy_q;
    logic          done_q;

    logic          pause_s;
    logic          launch_s;
    logic          step_s;
    logic [15:0]   lfsr_val_s;
    logic [15:0]   misr_val_s;

`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    assign launch_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign step_s   = (state_q == SAMPLE) && !pause_s;

    nlsc_lfsr16 #(.RESET_VAL(SEED_EFF)) u_lfsr (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (step_s),
        .load_i     (launch_s),
        .load_val_i (SEED_EFF),
        .din_i      (1'b0),
        .val_o      (lfsr_val_s)
    );

    nlsc_lfsr16 #(.RESET_VAL(16'h0000)) u_misr (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (step_s),
        .load_i     (launch_s),
        .load_val_i (16'h0000),
        .din_i      (resp),
        .val_o      (misr_val_s)
    );

    // Sequencer: apply, settle, sample per vector; counters advance only on a live sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            ones_q       <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= APPLY;
                        ones_q  <= '0;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!pause_s) begin
                        settle_cnt_q <= '0;
                        state_q      <= (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (!pause_s) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= SAMPLE;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (!pause_s) begin
                        ones_q <= ones_q + CW'(resp);
                        vec_q  <= vec_q + 1'b1;
                        if (vec_q == VEC_LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= APPLY;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bits of the LFSR above the cone width only feed the polynomial.
    generate
        if (IN_W < 16) begin : g_hi
            logic unused_lfsr_hi_s;
            assign unused_lfsr_hi_s = ^lfsr_val_s[15:IN_W];
        end
    endgenerate

    assign stim     = lfsr_val_s[IN_W-1:0];
    assign sig      = misr_val_s;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;
    assign vec_cnt  = vec_q;

endmodule

// File: tb/tb_netlist_stim_capture.sv
// Self-checking bench: three parameterisations share stimulus, a reference
// LFSR/MISR model fills a stim scoreboard and predicts signature, counts and timing.
module tb_netlist_stim_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_s;
    logic resp_s;
    int   sel;
    int   resp_mode;
    int   tests_run;
    int   tests_failed;
    logic [15:0] sig_unpaused;
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
    logic pause_s;
`endif

    logic [12:0] stim_a, stim_b, stim_c, stim_m;
    logic        busy_a, busy_b, busy_c, busy_m;
    logic        done_a, done_b, done_c, done_m;
    logic [15:0] sig_a, sig_b, sig_c, sig_m;
    logic [2:0]  ones_a, vec_a;
    logic [1:0]  ones_b, vec_b, ones_c, vec_c;
    logic [15:0] ones_m, vec_m;
    logic        start_a, start_b, start_c;

    assign start_a = start_s && (sel == 0);
    assign start_b = start_s && (sel == 1);
    assign start_c = start_s && (sel == 2);

    netlist_stim_capture #(.IN_W(13), .NUM_VEC(4), .SETTLE_CYC(2), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        .pause(pause_s),
`endif
        .start(start_a), .stim(stim_a), .resp(resp_s), .busy(busy_a), .done(done_a),
        .sig(sig_a), .ones_cnt(ones_a), .vec_cnt(vec_a));

    netlist_stim_capture #(.IN_W(13), .NUM_VEC(2), .SETTLE_CYC(1), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        .pause(pause_s),
`endif
        .start(start_b), .stim(stim_b), .resp(resp_s), .busy(busy_b), .done(done_b),
        .sig(sig_b), .ones_cnt(ones_b), .vec_cnt(vec_b));

    netlist_stim_capture #(.IN_W(13), .NUM_VEC(3), .SETTLE_CYC(0), .SEED(16'hACE1)) dut_c (
        .clk(clk), .rst_n(rst_n),
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        .pause(pause_s),
`endif
        .start(start_c), .stim(stim_c), .resp(resp_s), .busy(busy_c), .done(done_c),
        .sig(sig_c), .ones_cnt(ones_c), .vec_cnt(vec_c));

    always_comb begin
        case (sel)
            1: begin stim_m = stim_b; busy_m = busy_b; done_m = done_b; sig_m = sig_b;
                     ones_m = 16'(ones_b); vec_m = 16'(vec_b); end
            2: begin stim_m = stim_c; busy_m = busy_c; done_m = done_c; sig_m = sig_c;
                     ones_m = 16'(ones_c); vec_m = 16'(vec_c); end
            default: begin stim_m = stim_a; busy_m = busy_a; done_m = done_a; sig_m = sig_a;
                     ones_m = 16'(ones_a); vec_m = 16'(vec_a); end
        endcase
    end

    // Fake cone: constant 0, constant 1, or a parity of selected inputs.
    function automatic logic cone(input logic [12:0] st, input int mode);
        case (mode)
            1:       cone = 1'b1;
            2:       cone = ^(st & 13'h1A5B);
            default: cone = 1'b0;
        endcase
    endfunction

    assign resp_s = cone(stim_m, resp_mode);

    function automatic logic [15:0] step16(input logic [15:0] s, input logic d);
        logic [15:0] t;
        t = {1'b0, s[15:1]};
        if (s[0]) t = t ^ 16'hB400;
        t[0] = t[0] ^ d;
        return t;
    endfunction

    task automatic run_vec(input int nvec, input int settle, input int pause_at,
                           input int pause_len, input int mid_start_at,
                           output logic [12:0] first_stim, output logic [15:0] first_sig);
        logic [12:0] exp_q[$];
        logic [15:0] l, s;
        logic [12:0] prev, e;
        logic        r;
        int          ones, cyc;
        bit          busy_ok, got_stim, got_sig;
        l = 16'hACE1; s = 16'h0000; ones = 0;
        for (int i = 0; i < nvec; i++) begin
            r = cone(l[12:0], resp_mode);
            s = step16(s, r);
            ones += int'(r);
            l = step16(l, 1'b0);
            exp_q.push_back(l[12:0]);
        end
        first_stim = 13'h0000; first_sig = 16'h0000;
        got_stim = 0; got_sig = 0; busy_ok = 1;
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        tests_run++;
        if (stim_m !== 13'h0CE1 || busy_m !== 1'b1 || done_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL launch: stim=%h busy=%b done=%b, expected 0ce1/1/0", stim_m, busy_m, done_m);
        end
        prev = stim_m;
        cyc = 0;
        while (cyc < 2000) begin
            start_s = (cyc == mid_start_at);
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
            pause_s = (cyc >= pause_at) && (cyc < pause_at + pause_len);
`endif
            @(posedge clk); #1;
            cyc++;
            if (stim_m !== prev) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stim_extra: got %h with no expected vector left", stim_m);
                end else begin
                    e = exp_q.pop_front();
                    if (stim_m !== e) begin
                        tests_failed++;
                        $display("FAIL stim_seq: got %h expected %h", stim_m, e);
                    end
                end
                if (pause_len == 0) begin
                    tests_run++;
                    if (cyc % (2 + settle) != 0) begin
                        tests_failed++;
                        $display("FAIL stim_timing: changed at cycle %0d, expected multiple of %0d", cyc, 2 + settle);
                    end
                end
                if (!got_stim) begin first_stim = stim_m; got_stim = 1; end
                prev = stim_m;
            end
            if (vec_m == 16'd1 && !got_sig) begin first_sig = sig_m; got_sig = 1; end
            if (done_m === 1'b1) break;
            if (busy_m !== 1'b1) busy_ok = 0;
        end
        start_s = 1'b0;
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        pause_s = 1'b0;
`endif
        tests_run++;
        if (done_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done_m, cyc);
        end
        tests_run++;
        if (cyc != nvec * (2 + settle) + pause_len) begin
            tests_failed++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, nvec * (2 + settle) + pause_len);
        end
        tests_run++;
        if (sig_m !== s) begin
            tests_failed++;
            $display("FAIL sig: got %h expected %h", sig_m, s);
        end
        tests_run++;
        if (ones_m !== 16'(ones) || vec_m !== 16'(nvec)) begin
            tests_failed++;
            $display("FAIL counts: ones=%0d vec=%0d expected %0d/%0d", ones_m, vec_m, ones, nvec);
        end
        tests_run++;
        if (!busy_ok || busy_m !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL busy_window: busy_ok=%0d busy=%b left=%0d expected 1/0/0", busy_ok, busy_m, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (stim_a !== 13'h0CE1 || busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 16'h0000 ||
            ones_a !== 3'd0 || vec_a !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_a: stim=%h busy=%b done=%b sig=%h ones=%0d vec=%0d, expected 0ce1/0/0/0000/0/0",
                     stim_a, busy_a, done_a, sig_a, ones_a, vec_a);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (stim_c !== 13'h0CE1 || busy_c !== 1'b0 || done_c !== 1'b0 || sig_c !== 16'h0000) begin
            tests_failed++;
            $display("FAIL idle_c: stim=%h busy=%b done=%b sig=%h, expected 0ce1/0/0/0000", stim_c, busy_c, done_c, sig_c);
        end
    endtask

    task automatic test_resp0();
        logic [12:0] fs; logic [15:0] fg;
        sel = 0; resp_mode = 0;
        run_vec(4, 2, -1, 0, -1, fs, fg);
        tests_run++;
        if (sig_a !== 16'h0000 || ones_a !== 3'd0 || vec_a !== 3'd4) begin
            tests_failed++;
            $display("FAIL resp0_final: sig=%h ones=%0d vec=%0d expected 0000/0/4", sig_a, ones_a, vec_a);
        end
    endtask

    task automatic test_resp1();
        logic [12:0] fs; logic [15:0] fg;
        sel = 1; resp_mode = 1;
        run_vec(2, 1, -1, 0, -1, fs, fg);
        tests_run++;
        if (fs !== 13'h0270 || fg !== 16'h0001) begin
            tests_failed++;
            $display("FAIL resp1_first: stim2=%h sig1=%h expected 0270/0001", fs, fg);
        end
        tests_run++;
        if (sig_b !== 16'hB401 || ones_b !== 2'd2) begin
            tests_failed++;
            $display("FAIL resp1_final: sig=%h ones=%0d expected b401/2", sig_b, ones_b);
        end
    endtask

    task automatic test_signature();
        logic [12:0] fs; logic [15:0] fg;
        sel = 0; resp_mode = 2;
        run_vec(4, 2, -1, 0, -1, fs, fg);
        sig_unpaused = sig_a;
    endtask

    task automatic test_no_settle();
        logic [12:0] fs; logic [15:0] fg;
        sel = 2; resp_mode = 2;
        run_vec(3, 0, -1, 0, 3, fs, fg);
    endtask

    task automatic test_back_to_back();
        logic [12:0] fs; logic [15:0] fg;
        sel = 2; resp_mode = 1;
        run_vec(3, 0, -1, 0, -1, fs, fg);
        run_vec(3, 0, -1, 0, -1, fs, fg);
    endtask

    task automatic test_reset_midrun();
        logic [12:0] fs; logic [15:0] fg;
        sel = 0; resp_mode = 2;
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b1 || vec_a !== 3'd1) begin
            tests_failed++;
            $display("FAIL midrun_state: busy=%b vec=%0d expected 1/1", busy_a, vec_a);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (stim_a !== 13'h0CE1 || busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 16'h0000 ||
            ones_a !== 3'd0 || vec_a !== 3'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: stim=%h busy=%b done=%b sig=%h ones=%0d vec=%0d, expected 0ce1/0/0/0000/0/0",
                     stim_a, busy_a, done_a, sig_a, ones_a, vec_a);
        end
        @(negedge clk); rst_n = 1'b1;
        run_vec(4, 2, -1, 0, -1, fs, fg);
        tests_run++;
        if (sig_a !== sig_unpaused) begin
            tests_failed++;
            $display("FAIL rerun_sig: got %h expected %h", sig_a, sig_unpaused);
        end
    endtask

`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
    task automatic test_pause();
        logic [12:0] fs; logic [15:0] fg;
        sel = 0; resp_mode = 2;
        run_vec(4, 2, 1, 5, -1, fs, fg);
        tests_run++;
        if (sig_a !== sig_unpaused) begin
            tests_failed++;
            $display("FAIL pause_sig: got %h expected %h", sig_a, sig_unpaused);
        end
    endtask
`endif

    initial begin
        tests_run = 0; tests_failed = 0;
        start_s = 1'b0; sel = 0; resp_mode = 0; rst_n = 1'b0;
        sig_unpaused = 16'h0000;
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        pause_s = 1'b0;
`endif
        test_reset();
        test_resp0();
        test_resp1();
        test_signature();
        test_no_settle();
        test_back_to_back();
        test_reset_midrun();
`ifdef NETLIST_STIM_CAPTURE_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
